// File: rtl/log_scheduler_pkg.sv
// Shared types for the log-unit scheduler: FSM states and the
// saturation code returned when the log unit never answers.
package log_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    localparam logic [15:0] LOG_SAT = 16'h8000;

endpackage

// File: rtl/log_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request strictly after
// last_i, wrapping, as both a one-hot grant and an index.
module log_scheduler_rr_arbiter #(
    parameter int N_CH = 4,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = IW'((int'(last_i) + i) % N_CH);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/log_scheduler.sv
// Shares one multi-cycle log unit between N_CH mel channels, one
// conversion per channel per frame, results tagged with their channel.
module log_scheduler
    import log_scheduler_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 32,
    parameter int LOG_W   = 16,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH*DATA_W-1:0]   req_data,
    output logic [N_CH-1:0]          req_ready,
    output logic [DATA_W-1:0]        lu_data,
    output logic                     lu_valid,
    input  logic [LOG_W-1:0]         lu_result,
    input  logic                     lu_done,
    output logic                     res_valid,
    output logic [LOG_W-1:0]         res_data,
    output logic [$clog2(N_CH)-1:0]  res_ch,
    input  logic                     res_ready,
    output logic                     frame_done,
    output logic                     err_timeout,
    output logic                     busy
);

    localparam int IW = $clog2(N_CH);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [IW-1:0]     last_q, last_d;
    logic [DATA_W-1:0] lu_data_q, lu_data_d;
    logic [LOG_W-1:0]  res_data_q, res_data_d;
    logic [IW-1:0]     res_ch_q, res_ch_d;
    logic              fd_q, fd_d;
    logic              err_q, err_d;

    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   gnt;
    logic [IW-1:0]     gidx;
    logic              gany;
    logic [N_CH-1:0]   mask_set;
    logic [CW-1:0]     cnt_inc;

    assign eligible = req_valid & ~mask_q;
    assign mask_set = mask_q | (N_CH'(1) << res_ch_q);
    assign cnt_inc  = cnt_q + CW'(1);

    log_scheduler_rr_arbiter #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_arb (
        .req_i  (eligible),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gidx),
        .any_o  (gany)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            last_q     <= IW'(N_CH - 1);
            lu_data_q  <= '0;
            res_data_q <= '0;
            res_ch_q   <= '0;
            fd_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            lu_data_q  <= lu_data_d;
            res_data_q <= res_data_d;
            res_ch_q   <= res_ch_d;
            fd_q       <= fd_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        last_d     = last_q;
        lu_data_d  = lu_data_q;
        res_data_d = res_data_q;
        res_ch_d   = res_ch_q;
        fd_d       = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (gany) begin
                    lu_data_d = req_data[gidx*DATA_W +: DATA_W];
                    res_ch_d  = gidx;
                    last_d    = gidx;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // a result arriving on the timeout cycle is still taken
                if (lu_done) begin
                    res_data_d = lu_result;
                    state_d    = S_HOLD;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    res_data_d = LOG_W'(LOG_SAT);
                    err_d      = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    if (&mask_set) begin
                        mask_d = '0;
                        fd_d   = 1'b1;
                    end else begin
                        mask_d = mask_set;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE) ? gnt : '0;
        lu_valid  = (state_q == S_ISSUE);
        res_valid = (state_q == S_HOLD);
        busy      = (state_q != S_IDLE);
    end

    assign lu_data     = lu_data_q;
    assign res_data    = res_data_q;
    assign res_ch      = res_ch_q;
    assign frame_done  = fd_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_log_scheduler.sv
// Directed bench for log_scheduler: a table of per-transaction vectors
// plus hand sequences for idle hold, result back-pressure, timeout, reset.
module tb_log_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [31:0]  lu_data;
    logic         lu_valid;
    logic [15:0]  lu_result;
    logic         lu_done;
    logic         res_valid;
    logic [15:0]  res_data;
    logic [1:0]   res_ch;
    logic         res_ready;
    logic         frame_done;
    logic         err_timeout;
    logic         busy;

    always #5 clk = ~clk;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'h4000_0000;
    localparam logic [31:0] D3 = 32'h3333_0003;

    assign req_data = {D3, D2, D1, D0};

    log_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .lu_data     (lu_data),
        .lu_valid    (lu_valid),
        .lu_result   (lu_result),
        .lu_done     (lu_done),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ch      (res_ch),
        .res_ready   (res_ready),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    typedef struct {
        logic [3:0]  rv;
        int          lat;
        logic [15:0] res;
        int          ch;
        bit          fd;
    } row_t;

    row_t rows[12];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] dat(input int ch);
        case (ch)
            0:       return D0;
            1:       return D1;
            2:       return D2;
            default: return D3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic start_req(input logic [3:0] rv, input int ch);
        int n;
        req_valid = rv;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant", {28'b0, req_ready}, 32'(1) << ch);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("lu_valid", {31'b0, lu_valid}, 32'd1);
        chk("lu_data", lu_data, dat(ch));
        chk("busy", {31'b0, busy}, 32'd1);
    endtask

    task automatic give_done(input int lat, input logic [15:0] r);
        for (int k = 1; k <= lat; k++) @(negedge clk);
        lu_done   = 1'b1;
        lu_result = r;
        @(negedge clk);
        lu_done = 1'b0;
        #1;
    endtask

    task automatic check_res(input logic [15:0] d, input int ch);
        chk("res_valid", {31'b0, res_valid}, 32'd1);
        chk("res_data", {16'b0, res_data}, {16'b0, d});
        chk("res_ch", {30'b0, res_ch}, 32'(ch));
        chk("lu_data_held", lu_data, dat(ch));
    endtask

    task automatic take_res(input bit fd);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("frame_done", {31'b0, frame_done}, {31'b0, fd});
        chk("res_valid_clr", {31'b0, res_valid}, 32'd0);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            start_req(rows[i].rv, rows[i].ch);
            give_done(rows[i].lat, rows[i].res);
            check_res(rows[i].res, rows[i].ch);
            take_res(rows[i].fd);
            if (rows[i].fd) begin
                @(negedge clk);
                #1;
                chk("fd_one_cycle", {31'b0, frame_done}, 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        rows[0]  = '{4'b0100, 5, 16'h0123, 2, 1'b0};
        rows[1]  = '{4'b1111, 2, 16'h0AAA, 3, 1'b0};
        rows[2]  = '{4'b1111, 7, 16'h0BBB, 0, 1'b0};
        rows[3]  = '{4'b1111, 1, 16'h0CCC, 1, 1'b1};
        rows[4]  = '{4'b0010, 3, 16'h0DDD, 1, 1'b0};
        rows[5]  = '{4'b1111, 4, 16'h1EEE, 2, 1'b0};
        rows[6]  = '{4'b1111, 2, 16'h0F0F, 3, 1'b0};
        rows[7]  = '{4'b1111, 3, 16'h7FFF, 0, 1'b1};
        rows[8]  = '{4'b1111, 2, 16'h1111, 0, 1'b0};
        rows[9]  = '{4'b1111, 3, 16'h2222, 1, 1'b0};
        rows[10] = '{4'b1111, 4, 16'h3333, 2, 1'b0};
        rows[11] = '{4'b1111, 1, 16'h4444, 3, 1'b1};

        rst_n     = 1'b0;
        req_valid = '0;
        lu_result = '0;
        lu_done   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", {busy, res_valid, lu_valid, frame_done,
                         err_timeout, req_ready, res_data, 8'b0},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);

        // single channel, then finish that frame
        run_rows(0, 4);

        // ch1 already served: it must wait for the next frame
        req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("masked_idle", {27'b0, busy, req_ready}, 32'd0);
        end
        req_valid = '0;
        run_rows(5, 7);

        // back-pressure on the result, with a stray lu_done in HOLD
        start_req(4'b1111, 1);
        give_done(3, 16'h0A5A);
        check_res(16'h0A5A, 1);
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                lu_done   = 1'b1;
                lu_result = 16'hFFFF;
            end
            if (k == 4) lu_done = 1'b0;
            #1;
            chk("hold_stable", {11'b0, res_valid, req_ready, res_data},
                {11'b0, 1'b1, 4'b0, 16'h0A5A});
        end
        req_valid = '0;
        take_res(1'b0);

        // log unit never answers
        chk("err_before", {31'b0, err_timeout}, 32'd0);
        start_req(4'b0001, 0);
        first = 0;
        for (int k = 1; k <= 100 && first == 0; k++) begin
            @(negedge clk);
            #1;
            if (res_valid) first = k;
        end
        chk("timeout_lat", 32'(first), 32'd64);
        chk("sat_data", {16'b0, res_data}, 32'h0000_8000);
        chk("sat_ch", {30'b0, res_ch}, 32'd0);
        chk("err_set", {31'b0, err_timeout}, 32'd1);
        take_res(1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("err_sticky", {31'b0, err_timeout}, 32'd1);

        // reset while waiting on the log unit
        start_req(4'b0100, 2);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {busy, res_valid, lu_valid, frame_done,
                            err_timeout, req_ready, 8'b0, res_data},
            32'd0);
        chk("midrst_lu_data", lu_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lu_done   = 1'b1;
        lu_result = 16'h1234;
        @(negedge clk);
        lu_done = 1'b0;
        #1;
        chk("late_done_ignored", {30'b0, busy, res_valid}, 32'd0);

        // fresh frame after reset: order 0,1,2,3
        run_rows(8, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
